// File: rtl/hetero_coh_pkg.sv
// Shared types for the hetero coherence slice:
// tracker FSM states, directory line states, request codes.
package hetero_coh_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PROBE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } trk_state_e;

  typedef enum logic [1:0] {
    I = 2'd0,
    S = 2'd1,
    M = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    READ     = 2'd0,
    WRITE    = 2'd1,
    PROBEACK = 2'd2
  } req_type_e;

endpackage

// File: rtl/hetero_inval_tracker_if.sv
// Invalidation tracker bus: request, probe fan-out,
// ack collection and completion handshake.
interface hetero_inval_tracker_if #(
  parameter int unsigned N_CPU       = 4,
  parameter int unsigned N_GPU       = 8,
  parameter int unsigned LINE_ADDR_W = 32
);

  logic                   inv_valid;
  logic                   inv_ready;
  logic [LINE_ADDR_W-1:0] inv_addr;
  logic [N_CPU-1:0]       inv_cpu_mask;
  logic [N_GPU-1:0]       inv_gpu_mask;

  logic [N_CPU-1:0]       cpu_probe;
  logic [N_GPU-1:0]       gpu_probe;
  logic [LINE_ADDR_W-1:0] probe_addr;
  logic [N_CPU-1:0]       cpu_ack;
  logic [N_GPU-1:0]       gpu_ack;

  logic                   done_valid;
  logic [LINE_ADDR_W-1:0] done_addr;
  logic                   done_timeout;
  logic                   done_ready;
  logic                   stray_ack;

  modport master (
    output inv_valid, inv_addr,
    output inv_cpu_mask, inv_gpu_mask,
    output cpu_ack, gpu_ack, done_ready,
    input  inv_ready, cpu_probe, gpu_probe,
    input  probe_addr, done_valid,
    input  done_addr, done_timeout, stray_ack
  );

  modport slave (
    input  inv_valid, inv_addr,
    input  inv_cpu_mask, inv_gpu_mask,
    input  cpu_ack, gpu_ack, done_ready,
    output inv_ready, cpu_probe, gpu_probe,
    output probe_addr, done_valid,
    output done_addr, done_timeout, stray_ack
  );

endinterface

// File: rtl/hetero_ack_timer.sv
// Wait-cycle timer plus re-probe retry counter;
// both saturate instead of wrapping.
module hetero_ack_timer #(
  parameter int unsigned TIMEOUT   = 1023,
  parameter int unsigned MAX_RETRY = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic start_i,
  input  logic tick_i,
  input  logic retry_i,
  output logic expire_o,
  output logic exhausted_o
);

  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  localparam int unsigned RW =
    (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0] T_MAX  = TW'(TIMEOUT);
  localparam logic [RW-1:0] R_MAX  = RW'(MAX_RETRY);

  logic [TW-1:0] timer_q, timer_d;
  logic [RW-1:0] retry_q, retry_d;

  always_comb begin
    timer_d = timer_q;
    retry_d = retry_q;
    if (clear_i) begin
      timer_d = '0;
      retry_d = '0;
    end else begin
      if (start_i)
        timer_d = '0;
      else if (tick_i && timer_q != T_MAX)
        timer_d = timer_q + 1'b1;
      if (retry_i && retry_q != R_MAX)
        retry_d = retry_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      timer_q <= '0;
      retry_q <= '0;
    end else begin
      timer_q <= timer_d;
      retry_q <= retry_d;
    end
  end

  assign expire_o    = (timer_q == T_LAST);
  assign exhausted_o = (retry_q == R_MAX);

endmodule

// File: rtl/hetero_inval_tracker.sv
// Fans out invalidation probes to CPU/GPU clients,
// collects acks, re-probes stragglers, reports done.
module hetero_inval_tracker
  import hetero_coh_pkg::*;
#(
  parameter int unsigned N_CPU       = 4,
  parameter int unsigned N_GPU       = 8,
  parameter int unsigned LINE_ADDR_W = 32,
  parameter int unsigned TIMEOUT     = 1023,
  parameter int unsigned MAX_RETRY   = 3
) (
  input logic                  clk,
  input logic                  rst,
  hetero_inval_tracker_if.slave bus
);

  trk_state_e             state_q;
  logic [LINE_ADDR_W-1:0] addr_q;
  logic [N_CPU-1:0]       pend_cpu_q;
  logic [N_GPU-1:0]       pend_gpu_q;
  logic [N_CPU-1:0]       cpu_probe_q;
  logic [N_GPU-1:0]       gpu_probe_q;
  logic                   done_valid_q;
  logic                   done_to_q;
  logic                   stray_q;

  logic [N_CPU-1:0] cpu_left;
  logic [N_GPU-1:0] gpu_left;
  logic             all_clr;
  logic             busy;
  logic             stray_hit;
  logic             expire;
  logic             exhausted;
  logic             retry_go;

  assign cpu_left = pend_cpu_q & ~bus.cpu_ack;
  assign gpu_left = pend_gpu_q & ~bus.gpu_ack;
  assign all_clr  = ~|{cpu_left, gpu_left};
  assign busy     = (state_q == PROBE) ||
                    (state_q == WAIT);

  // Outside PROBE/WAIT nothing is pending, so any ack is stray.
  always_comb begin
    stray_hit = 1'b0;
    if (busy)
      stray_hit = |(bus.cpu_ack & ~pend_cpu_q) |
                  |(bus.gpu_ack & ~pend_gpu_q);
    else
      stray_hit = |bus.cpu_ack | |bus.gpu_ack;
  end

  assign retry_go = (state_q == WAIT) && !all_clr &&
                    expire && !exhausted;

  hetero_ack_timer #(
    .TIMEOUT  (TIMEOUT),
    .MAX_RETRY(MAX_RETRY)
  ) u_timer (
    .clk        (clk),
    .rst        (rst),
    .clear_i    (state_q == IDLE),
    .start_i    (state_q == PROBE),
    .tick_i     (state_q == WAIT),
    .retry_i    (retry_go),
    .expire_o   (expire),
    .exhausted_o(exhausted)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      pend_cpu_q   <= '0;
      pend_gpu_q   <= '0;
      cpu_probe_q  <= '0;
      gpu_probe_q  <= '0;
      done_valid_q <= 1'b0;
      done_to_q    <= 1'b0;
      stray_q      <= 1'b0;
    end else begin
      cpu_probe_q <= '0;
      gpu_probe_q <= '0;
      if (stray_hit)
        stray_q <= 1'b1;
      unique case (state_q)
        IDLE: begin
          if (bus.inv_valid) begin
            addr_q     <= bus.inv_addr;
            pend_cpu_q <= bus.inv_cpu_mask;
            pend_gpu_q <= bus.inv_gpu_mask;
            if (~|{bus.inv_cpu_mask,
                   bus.inv_gpu_mask}) begin
              state_q      <= DONE;
              done_valid_q <= 1'b1;
              done_to_q    <= 1'b0;
            end else begin
              state_q     <= PROBE;
              cpu_probe_q <= bus.inv_cpu_mask;
              gpu_probe_q <= bus.inv_gpu_mask;
            end
          end
        end
        PROBE: begin
          pend_cpu_q <= cpu_left;
          pend_gpu_q <= gpu_left;
          // Same-cycle acks can finish before WAIT.
          if (all_clr) begin
            state_q      <= DONE;
            done_valid_q <= 1'b1;
            done_to_q    <= 1'b0;
          end else begin
            state_q <= WAIT;
          end
        end
        WAIT: begin
          pend_cpu_q <= cpu_left;
          pend_gpu_q <= gpu_left;
          if (all_clr) begin
            state_q      <= DONE;
            done_valid_q <= 1'b1;
            done_to_q    <= 1'b0;
          end else if (expire) begin
            if (!exhausted) begin
              state_q     <= PROBE;
              cpu_probe_q <= cpu_left;
              gpu_probe_q <= gpu_left;
            end else begin
              state_q      <= DONE;
              done_valid_q <= 1'b1;
              done_to_q    <= 1'b1;
            end
          end
        end
        DONE: begin
          if (bus.done_ready) begin
            state_q      <= IDLE;
            done_valid_q <= 1'b0;
            done_to_q    <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.inv_ready    = (state_q == IDLE);
  assign bus.cpu_probe    = cpu_probe_q;
  assign bus.gpu_probe    = gpu_probe_q;
  assign bus.probe_addr   =
    |{cpu_probe_q, gpu_probe_q} ? addr_q : '0;
  assign bus.done_valid   = done_valid_q;
  assign bus.done_addr    = done_valid_q ? addr_q : '0;
  assign bus.done_timeout = done_to_q;
  assign bus.stray_ack    = stray_q;

endmodule
